// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and round-robin pick helper for the FIFO write-side arbiter.
package sync_fifo_arb_pkg;

    typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

    localparam int unsigned STATS_W = 16;

    // Widest requester set the pick helper supports.
    localparam int unsigned MAX_REQ = 32;
    localparam int unsigned IDX_W   = 5;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate valid so ptr sits at bit 0, take the lowest set bit, un-rotate the index.
    // Only the first n bits of valid take part; n need not be a power of two.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        n);
        rr_pick_t         res;
        logic [MAX_REQ-1:0] rot;
        int unsigned      j;
        res = '0;
        rot = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                j = 32'(ptr) + i;
                if (j >= n) j = j - n;
                rot[i] = valid[j[IDX_W-1:0]];
            end
        end
        // Scan downward so the lowest set rotated bit is written last and wins.
        for (int unsigned i = MAX_REQ; i > 0; i--) begin
            if (rot[i-1]) begin
                j = 32'(ptr) + i - 1;
                if (j >= n) j = j - n;
                res.found = 1'b1;
                res.idx   = j[IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid index at or above ptr_i, with wrap.
module rr_priority_picker
    import sync_fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic                 found_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int unsigned PTR_W = $clog2(N);

    rr_pick_t pick;

    // Rotate / priority-encode / un-rotate via the shared helper.
    always_comb begin
        pick    = rr_pick(MAX_REQ'(valid_i), IDX_W'(ptr_i), N);
        found_o = pick.found;
        idx_o   = PTR_W'(pick.idx);
    end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between N_REQ producers.
// A grant is held for up to MAX_BURST accepted words; each release costs one IDLE cycle.
// Optional per-requester beat counters are built when SYNC_FIFO_ARB_STATS_EN is defined.
module sync_fifo_wr_arbiter
    import sync_fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic                        fifo_full_i,
    output logic                        fifo_write_o,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data_o,
    output logic [N_REQ-1:0]            grant_o,
    output logic                        busy_o
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic [N_REQ*STATS_W-1:0]    grant_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(N_REQ - 1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    logic             owner_valid;
    logic             beat;
    logic             release_grant;

    rr_priority_picker #(
        .N (N_REQ)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Handshake and write-port drive; ready follows fifo_full_i combinationally.
    always_comb begin
        owner_valid    = |(req_valid_i & grant_q);
        beat           = (state_q == GRANT) && owner_valid && !fifo_full_i;
        fifo_write_o   = beat;
        req_ready_o    = ((state_q == GRANT) && !fifo_full_i) ? grant_q : '0;
        fifo_wr_data_o = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            fifo_wr_data_o = fifo_wr_data_o
                           | (req_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
        grant_o = grant_q;
        busy_o  = (state_q == GRANT);
    end

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        release_grant = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d     = GRANT;
                    grant_d     = N_REQ'(1) << pick_idx;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    release_grant = 1'b1;
                end else if (!fifo_full_i) begin
                    if (burst_cnt_q == LAST_BEAT) release_grant = 1'b1;
                    else                          burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
                // Full with owner valid: everything holds.
                if (release_grant) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (owner_q == LAST_REQ) ? '0 : owner_q + PTR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [STATS_W-1:0] cnt_q [N_REQ];
    logic [STATS_W-1:0] cnt_d [N_REQ];

    // Saturating beat counters; clear wins over a same-cycle increment.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr_i)                               cnt_d[i] = '0;
            else if (beat && grant_q[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + STATS_W'(1);
            grant_cnt_o[i*STATS_W +: STATS_W] = cnt_q[i];
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Self-checking bench for sync_fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a requester-level reference model.
module tb_sync_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   vld;
    logic [N*W-1:0] dat;
    logic [N-1:0]   rdy;
    logic           full;
    logic           wr;
    logic [W-1:0]   wdata;
    logic [N-1:0]   gnt;
    logic           busy;
`ifdef SYNC_FIFO_ARB_STATS_EN
    logic           clr;
    logic [N*16-1:0] gcnt;
`endif

    int checks = 0;
    int passed = 0;

    // Reference model: current owner (-1 when idle), next start index, beats in this grant.
    int m_owner;
    int m_ptr;
    int m_beats;

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (vld),
        .req_data_i     (dat),
        .req_ready_o    (rdy),
        .fifo_full_i    (full),
        .fifo_write_o   (wr),
        .fifo_wr_data_o (wdata),
        .grant_o        (gnt),
        .busy_o         (busy)
`ifdef SYNC_FIFO_ARB_STATS_EN
        ,
        .stats_clr_i    (clr),
        .grant_cnt_o    (gcnt)
`endif
    );

    function automatic logic [W-1:0] w(int i, int k);
        return {8'hA5, 8'(i), 16'(k)};
    endfunction

    task automatic set_word(int i, logic [W-1:0] v);
        dat[i*W +: W] = v;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    // One clock of the arbitration rules, using the inputs present at the edge.
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && vld[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_beats = 0;
                end
            end
        end else if (!vld[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!full) begin
            m_beats++;
            if (m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        vld  = '0;
        full = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (gnt !== '0)   $display("FAIL reset_grant: got %b want 0", gnt);   else passed++;
        checks++; if (wr !== 1'b0)  $display("FAIL reset_write: got %b want 0", wr);    else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);  else passed++;
        checks++; if (rdy !== '0)   $display("FAIL reset_ready: got %b want 0", rdy);   else passed++;
        checks++; if (wdata !== '0) $display("FAIL reset_data: got %h want 0", wdata);  else passed++;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single();
        set_word(2, w(2, 0));
        vld[2] = 1'b1;
        #1;
        checks++; if (gnt !== '0 || wr !== 1'b0) $display("FAIL single_idle: got gnt=%b wr=%b want 0000/0", gnt, wr); else passed++;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (gnt !== 4'b0100) $display("FAIL single_grant: got %b want 0100", gnt); else passed++;
            checks++; if (rdy !== 4'b0100) $display("FAIL single_ready: got %b want 0100", rdy); else passed++;
            checks++; if (wr !== 1'b1 || wdata !== w(2, k)) $display("FAIL single_write: got wr=%b data=%h want 1/%h", wr, wdata, w(2, k)); else passed++;
            tick();
            if (k < 2) set_word(2, w(2, k + 1));
            else       vld[2] = 1'b0;
        end
        #1;
        checks++; if (gnt !== 4'b0100 || wr !== 1'b0) $display("FAIL single_release: got gnt=%b wr=%b want 0100/0", gnt, wr); else passed++;
        tick();
        #1;
        checks++; if (gnt !== '0 || busy !== 1'b0) $display("FAIL single_idle_after: got gnt=%b busy=%b want 0000/0", gnt, busy); else passed++;
        tick();
    endtask

    task automatic test_rr_skip();
        // Park the pointer at 2 by granting and immediately releasing requester 1.
        set_word(1, w(1, 0));
        vld = 4'b0010;
        tick();
        vld = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0010 || wr !== 1'b0) $display("FAIL rr_park: got gnt=%b wr=%b want 0010/0", gnt, wr); else passed++;
        tick();
        set_word(3, w(3, 0));
        vld = 4'b1010;
        tick();
        #1;
        checks++; if (gnt !== 4'b1000) $display("FAIL rr_first: got %b want 1000", gnt); else passed++;
        checks++; if (wr !== 1'b1 || wdata !== w(3, 0)) $display("FAIL rr_first_data: got wr=%b data=%h want 1/%h", wr, wdata, w(3, 0)); else passed++;
        tick();
        vld[3] = 1'b0;
        tick();
        tick();
        #1;
        checks++; if (gnt !== 4'b0010) $display("FAIL rr_second: got %b want 0010", gnt); else passed++;
        vld = '0;
        tick();
        tick();
    endtask

    task automatic test_all_valid();
        int cnt [N];
        int owner;
        int total;
        logic [N-1:0] eg;
        do_reset();
        total = 0;
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            set_word(i, w(i, 0));
        end
        vld = '1;
        // Nine-cycle period: one idle cycle then MB write cycles, owners in order 0,1,2,3,0.
        for (int c = 0; c < 45; c++) begin
            owner = (c / 9) % N;
            eg    = (c % 9 == 0) ? '0 : (N'(1) << owner);
            #1;
            checks++; if (gnt !== eg) $display("FAIL all_grant c=%0d: got %b want %b", c, gnt, eg); else passed++;
            checks++; if (wr !== (eg != '0)) $display("FAIL all_write c=%0d: got %b want %b", c, wr, eg != '0); else passed++;
            if (eg != '0) begin
                checks++; if (wdata !== w(owner, cnt[owner])) $display("FAIL all_data c=%0d: got %h want %h", c, wdata, w(owner, cnt[owner])); else passed++;
            end
            if (wr) total++;
            tick();
            if (eg != '0) begin
                cnt[owner]++;
                set_word(owner, w(owner, cnt[owner]));
            end
        end
        checks++; if (total != 5 * MB) $display("FAIL all_total_writes: got %0d want %0d", total, 5 * MB); else passed++;
        vld = '0;
        tick();
        tick();
    endtask

    task automatic test_full_stall();
        int  nw;
        int  stalls;
        bit  done;
        do_reset();
        nw     = 0;
        stalls = 0;
        done   = 0;
        set_word(0, w(0, 0));
        vld = 4'b0001;
        tick();
        for (int c = 0; c < 40 && !done; c++) begin
            full = (nw == 3 && stalls < 5);
            #1;
            if (full) begin
                checks++; if (wr !== 1'b0) $display("FAIL stall_write: got %b want 0", wr); else passed++;
                checks++; if (rdy !== '0) $display("FAIL stall_ready: got %b want 0000", rdy); else passed++;
                checks++; if (gnt !== 4'b0001) $display("FAIL stall_grant: got %b want 0001", gnt); else passed++;
                stalls++;
            end
            if (wr) begin
                checks++; if (wdata !== w(0, nw)) $display("FAIL stall_data: got %h want %h", wdata, w(0, nw)); else passed++;
                nw++;
            end
            if (gnt == '0) done = 1;
            tick();
            if (!done) set_word(0, w(0, nw));
        end
        full = 1'b0;
        checks++; if (nw != MB) $display("FAIL stall_burst_len: got %0d want %0d", nw, MB); else passed++;
        vld = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_word(0, w(0, 0));
        vld = 4'b0001;
        tick();
        tick();
        vld = 4'b0000;
        tick();
        set_word(1, w(1, 0));
        vld = 4'b0010;
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            set_word(1, w(1, k + 1));
        end
        #1;
        checks++; if (wr !== 1'b1 || gnt !== 4'b0010) $display("FAIL mid_beat4: got wr=%b gnt=%b want 1/0010", wr, gnt); else passed++;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (gnt !== '0 || busy !== 1'b0) $display("FAIL mid_async_grant: got gnt=%b busy=%b want 0000/0", gnt, busy); else passed++;
        checks++; if (wr !== 1'b0 || rdy !== '0 || wdata !== '0) $display("FAIL mid_async_write: got wr=%b rdy=%b data=%h want 0", wr, rdy, wdata); else passed++;
        model_reset();
        vld = '1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (gnt !== '0) $display("FAIL mid_after_rst: got %b want 0000", gnt); else passed++;
        tick();
        #1;
        checks++; if (gnt !== 4'b0001) $display("FAIL mid_restart: got %b want 0001", gnt); else passed++;
        vld = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rdy;
        logic         e_wr;
        logic [W-1:0] e_data;
        int           acc;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    set_word(i, $urandom);
                end
            end
            #1;
            e_gnt  = (m_owner < 0) ? '0 : (N'(1) << m_owner);
            e_rdy  = (m_owner >= 0 && !full) ? e_gnt : '0;
            e_wr   = (m_owner >= 0) && vld[m_owner] && !full;
            e_data = (m_owner >= 0) ? dat[m_owner*W +: W] : '0;
            checks++; if (gnt !== e_gnt) $display("FAIL rand_grant c=%0d: got %b want %b", c, gnt, e_gnt); else passed++;
            checks++; if (rdy !== e_rdy) $display("FAIL rand_ready c=%0d: got %b want %b", c, rdy, e_rdy); else passed++;
            checks++; if (wr !== e_wr) $display("FAIL rand_write c=%0d: got %b want %b", c, wr, e_wr); else passed++;
            checks++; if (wdata !== e_data) $display("FAIL rand_data c=%0d: got %h want %h", c, wdata, e_data); else passed++;
            checks++; if (busy !== (m_owner >= 0)) $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, m_owner >= 0); else passed++;
            checks++; if (wr && full) $display("FAIL rand_overflow c=%0d: got write=1 while full want 0", c); else passed++;
            acc = e_wr ? m_owner : -1;
            tick();
            if (acc >= 0) begin
                if ($urandom_range(0, 1) == 0) vld[acc] = 1'b0;
                else                           set_word(acc, $urandom);
            end
        end
        vld  = '0;
        full = 1'b0;
        tick();
        tick();
    endtask

`ifdef SYNC_FIFO_ARB_STATS_EN
    task automatic test_stats();
        int beats;
        do_reset();
        beats = 0;
        set_word(0, w(0, 0));
        vld = 4'b0001;
        for (int c = 0; c < 80000 && beats < 65540; c++) begin
            #1;
            if (wr) beats++;
            tick();
        end
        #1;
        checks++; if (gcnt[15:0] !== 16'hFFFF) $display("FAIL stats_saturate: got %h want ffff", gcnt[15:0]); else passed++;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        checks++; if (gcnt[15:0] !== 16'h0000) $display("FAIL stats_clear: got %h want 0000", gcnt[15:0]); else passed++;
        vld = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        rst  = 1'b1;
        vld  = '0;
        dat  = '0;
        full = 1'b0;
`ifdef SYNC_FIFO_ARB_STATS_EN
        clr  = 1'b0;
`endif
        model_reset();
        test_reset();
        test_single();
        test_rr_skip();
        test_all_valid();
        test_full_stall();
        test_reset_mid_burst();
        test_random();
`ifdef SYNC_FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
